// File: rtl/out_queue.sv
// Request FIFO between the core and the 7-segment display stage.
// Each queued entry is issued as one paced outdisplay strobe.
module out_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2,
   parameter int GAP    = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_sel,
   input  logic [15:0]       req_val1,
   input  logic [15:0]       req_val2,
   input  logic              flush,
   output logic [15:0]       outval1,
   output logic [15:0]       outval2,
   output logic [2:0]        outsel,
   output logic              outdisplay,
   output logic [ADDR_W:0]   count
);

   localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);
   localparam logic [ADDR_W:0] FULL   = (ADDR_W + 1)'(DEPTH);
   localparam logic [GW-1:0]   GAP_LD = GW'(GAP);

   typedef struct packed {
      logic [2:0]  sel;
      logic [15:0] val1;
      logic [15:0] val2;
   } entry_t;

   entry_t             mem [DEPTH];
   entry_t             head;
   logic [ADDR_W-1:0]  wr_ptr;
   logic [ADDR_W-1:0]  rd_ptr;
   logic [GW-1:0]      gcnt;
   logic               push;
   logic               pop;

   // NOTE: ready looks only at the registered count, so a slot freed by a pop
   // on this edge is not offered until the next cycle (no ready->pop path).
   assign req_ready = !reset && (count < FULL);
   assign push      = req_valid && req_ready && !flush;
   assign pop       = (gcnt == '0) && (count != '0) && !flush;
   assign head      = mem[rd_ptr];

   // NOTE: storage has no reset; occupancy is tracked by count, so stale
   // contents are never read.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= '{sel: req_sel, val1: req_val1, val2: req_val2};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         gcnt       <= '0;
         outval1    <= '0;
         outval2    <= '0;
         outsel     <= '0;
         outdisplay <= 1'b0;
      end else if (flush) begin
         // Pacing survives a flush, value registers keep their last issue.
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         outdisplay <= 1'b0;
         if (gcnt != '0) gcnt <= gcnt - GW'(1);
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);

         if (pop) begin
            rd_ptr     <= rd_ptr + ADDR_W'(1);
            outval1    <= head.val1;
            outval2    <= head.val2;
            outsel     <= head.sel;
            outdisplay <= 1'b1;
            gcnt       <= GAP_LD;
         end else begin
            outdisplay <= 1'b0;
            if (gcnt != '0) gcnt <= gcnt - GW'(1);
         end

         case ({push, pop})
            2'b10:   count <= count + (ADDR_W + 1)'(1);
            2'b01:   count <= count - (ADDR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
